// File: rtl/lfsr4_pkg.sv
// Shared definitions for the 4-bit LFSR pattern generator and checker:
// next-state function, checker FSM states and the generator seed.
package lfsr4_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } lfsr4_state_e;

    localparam logic [3:0] LFSR4_SEED = 4'b1111;

    // One step of the 15-state sequence; all-zero maps to itself.
    function automatic logic [3:0] lfsr4_next(input logic [3:0] s);
        return {s[2], s[1], s[0] ^ s[3], s[3]};
    endfunction

endpackage

// File: rtl/lfsr4_checker_if.sv
// Checker data/status bundle.
// master: word source + status sink; slave: the checker itself.
interface lfsr4_checker_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [3:0]       in_data;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] word_count;

    modport master (
        output in_valid, in_data, clear_cnt,
        input  locked, err_pulse, err_count, word_count
    );

    modport slave (
        input  in_valid, in_data, clear_cnt,
        output locked, err_pulse, err_count, word_count
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Ports: clk, reset_n (sync, active-low), clr, inc, count.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/lfsr4_checker.sv
// Self-synchronising checker for the 4-bit LFSR pattern stream.
// Ports: clk, reset_n (sync, active-low), bus (slave): in_valid,
// in_data, clear_cnt in; locked, err_pulse, err_count, word_count out.
module lfsr4_checker
    import lfsr4_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic           clk,
    input  logic           reset_n,
    lfsr4_checker_if.slave bus
);
    localparam logic [3:0] LOCK_M1  = 4'(LOCK_CNT - 1);
    localparam logic [3:0] UNLOCK_M = 4'(UNLOCK_CNT);

    lfsr4_state_e state_d, state_q;
    logic [3:0]   expected_d, expected_q;
    logic [3:0]   match_d, match_q;
    logic [3:0]   miss_d, miss_q;
    logic         err_d, err_q;
    logic         locked_d, locked_q;
    logic         err_inc;
    logic         word_inc;
    logic [3:0]   d;

    assign d = bus.in_data;

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        match_d    = match_q;
        miss_d     = miss_q;
        err_d      = 1'b0;
        err_inc    = 1'b0;
        word_inc   = 1'b0;
        if (bus.in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (d != 4'b0000) begin
                        expected_d = lfsr4_next(d);
                        match_d    = 4'd0;
                        miss_d     = 4'd0;
                        state_d    = (LOCK_CNT == 1) ? LOCKED : SYNC;
                    end
                end
                SYNC: begin
                    if (d == expected_q) begin
                        expected_d = lfsr4_next(d);
                        match_d    = match_q + 4'd1;
                        if (match_q + 4'd1 == LOCK_M1) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else if (d != 4'b0000) begin
                        expected_d = lfsr4_next(d);
                        match_d    = 4'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Flywheel: never reseed from received data here.
                    expected_d = lfsr4_next(expected_q);
                    word_inc   = 1'b1;
                    if (d != expected_q) begin
                        err_d   = 1'b1;
                        err_inc = 1'b1;
                        miss_d  = miss_q + 4'd1;
                        if (miss_q + 4'd1 == UNLOCK_M) begin
                            state_d = HUNT;
                            match_d = 4'd0;
                        end
                    end else begin
                        miss_d = 4'd0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= HUNT;
            expected_q <= 4'b0000;
            match_q    <= 4'd0;
            miss_q     <= 4'd0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (bus.clear_cnt),
        .inc     (err_inc),
        .count   (bus.err_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (bus.clear_cnt),
        .inc     (word_inc),
        .count   (bus.word_count)
    );

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_q;
endmodule

// File: tb/tb_lfsr4_checker.sv
// Directed bench for lfsr4_checker: default instance plus a
// CNT_W=4 / UNLOCK_CNT=15 instance for counter saturation.
module tb_lfsr4_checker;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    // Generator sequence from 1111, written out by hand.
    logic [3:0] seq [15] = '{
        4'b1111, 4'b1101, 4'b1001, 4'b0001, 4'b0010,
        4'b0100, 4'b1000, 4'b0011, 4'b0110, 4'b1100,
        4'b1011, 4'b0101, 4'b1010, 4'b0111, 4'b1110
    };

    lfsr4_checker_if #(.CNT_W(16)) bus ();
    lfsr4_checker_if #(.CNT_W(4))  bus2 ();

    lfsr4_checker #(
        .LOCK_CNT(4), .UNLOCK_CNT(3), .CNT_W(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    lfsr4_checker #(
        .LOCK_CNT(4), .UNLOCK_CNT(15), .CNT_W(4)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 4'b0000;
        bus.clear_cnt = 1'b0;
        bus2.in_valid = 1'b0;
        bus2.in_data = 4'b0000;
        bus2.clear_cnt = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic word(input logic [3:0] w);
        bus.in_valid = 1'b1;
        bus.in_data = w;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic word2(input logic [3:0] w);
        bus2.in_valid = 1'b1;
        bus2.in_data = w;
        tick();
        bus2.in_valid = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic lock_up();
        for (int i = 0; i < 4; i++) word(seq[i]);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL rst_locked got=%0b exp=0", bus.locked);
        end
        checks++;
        if (bus.err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL rst_err_pulse got=%0b exp=0", bus.err_pulse);
        end
        checks++;
        if (bus.err_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_err_count got=%0d exp=0", bus.err_count);
        end
        checks++;
        if (bus.word_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_word_count got=%0d exp=0", bus.word_count);
        end
    endtask

    task automatic test_lock_from_reset();
        do_reset();
        for (int i = 0; i < 3; i++) word(seq[i]);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early got=%0b exp=0", bus.locked);
        end
        word(seq[3]);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_rise got=%0b exp=1", bus.locked);
        end
        for (int i = 4; i < 15; i++) word(seq[i]);
        checks++;
        if (bus.word_count !== 16'd11) begin
            errors++;
            $display("FAIL lock_words got=%0d exp=11", bus.word_count);
        end
        checks++;
        if (bus.err_count !== 16'd0) begin
            errors++;
            $display("FAIL lock_errs got=%0d exp=0", bus.err_count);
        end
    endtask

    task automatic test_single_error();
        do_reset();
        lock_up();
        for (int i = 4; i < 7; i++) word(seq[i]);
        word(4'b0111);
        checks++;
        if (bus.err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse got=%0b exp=1", bus.err_pulse);
        end
        checks++;
        if (bus.err_count !== 16'd1) begin
            errors++;
            $display("FAIL single_cnt got=%0d exp=1", bus.err_count);
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL single_locked got=%0b exp=1", bus.locked);
        end
        word(seq[8]);
        checks++;
        if (bus.err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL single_next_pulse got=%0b exp=0", bus.err_pulse);
        end
        checks++;
        if (bus.err_count !== 16'd1) begin
            errors++;
            $display("FAIL single_next_cnt got=%0d exp=1", bus.err_count);
        end
        checks++;
        if (bus.word_count !== 16'd5) begin
            errors++;
            $display("FAIL single_words got=%0d exp=5", bus.word_count);
        end
    endtask

    task automatic test_loss_of_lock();
        do_reset();
        lock_up();
        word(seq[5]);
        word(seq[6]);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL loss_hold got=%0b exp=1", bus.locked);
        end
        word(seq[7]);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL loss_drop got=%0b exp=0", bus.locked);
        end
        checks++;
        if (bus.err_count !== 16'd3) begin
            errors++;
            $display("FAIL loss_cnt got=%0d exp=3", bus.err_count);
        end
        for (int i = 9; i < 12; i++) word(seq[i]);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early got=%0b exp=0", bus.locked);
        end
        word(seq[12]);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL relock got=%0b exp=1", bus.locked);
        end
    endtask

    task automatic test_zero_handling();
        do_reset();
        repeat (5) word(4'b0000);
        word(4'b1000);
        word(4'b0011);
        word(4'b0110);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL zero_early got=%0b exp=0", bus.locked);
        end
        word(4'b1100);
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL zero_lock got=%0b exp=1", bus.locked);
        end
        word(4'b0000);
        word(4'b0000);
        checks++;
        if (bus.locked !== 1'b1 || bus.err_count !== 16'd2) begin
            errors++;
            $display("FAIL zero_stuck2 locked=%0b errs=%0d exp=1/2",
                     bus.locked, bus.err_count);
        end
        word(4'b0000);
        checks++;
        if (bus.locked !== 1'b0 || bus.err_count !== 16'd3) begin
            errors++;
            $display("FAIL zero_stuck3 locked=%0b errs=%0d exp=0/3",
                     bus.locked, bus.err_count);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        lock_up();
        for (int i = 4; i < 7; i++) begin
            word(seq[i]);
            idle();
            idle();
        end
        checks++;
        if (bus.err_count !== 16'd0 || bus.word_count !== 16'd3) begin
            errors++;
            $display("FAIL gaps errs=%0d words=%0d exp=0/3",
                     bus.err_count, bus.word_count);
        end
        checks++;
        if (bus.locked !== 1'b1) begin
            errors++;
            $display("FAIL gaps_locked got=%0b exp=1", bus.locked);
        end
        word(seq[8]);
        checks++;
        if (bus.err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL gap_pulse got=%0b exp=1", bus.err_pulse);
        end
        idle();
        checks++;
        if (bus.err_pulse !== 1'b0 || bus.err_count !== 16'd1) begin
            errors++;
            $display("FAIL gap_idle pulse=%0b errs=%0d exp=0/1",
                     bus.err_pulse, bus.err_count);
        end
    endtask

    task automatic test_clear();
        do_reset();
        lock_up();
        word(seq[5]);
        bus.clear_cnt = 1'b1;
        word(seq[4]);
        bus.clear_cnt = 1'b0;
        checks++;
        if (bus.err_count !== 16'd0 || bus.word_count !== 16'd0) begin
            errors++;
            $display("FAIL clear errs=%0d words=%0d exp=0/0",
                     bus.err_count, bus.word_count);
        end
        checks++;
        if (bus.err_pulse !== 1'b1) begin
            errors++;
            $display("FAIL clear_pulse got=%0b exp=1", bus.err_pulse);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4; i++) word2(seq[i]);
        repeat (15) word2(4'b0000);
        checks++;
        if (bus2.err_count !== 4'd15 || bus2.locked !== 1'b0) begin
            errors++;
            $display("FAIL sat_first errs=%0d locked=%0b exp=15/0",
                     bus2.err_count, bus2.locked);
        end
        for (int i = 0; i < 4; i++) word2(seq[i]);
        repeat (5) word2(4'b0000);
        checks++;
        if (bus2.err_count !== 4'd15 || bus2.locked !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold errs=%0d locked=%0b exp=15/1",
                     bus2.err_count, bus2.locked);
        end
        checks++;
        if (bus2.word_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_words got=%0d exp=15", bus2.word_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lock_up();
        word(seq[7]);
        reset_n = 1'b0;
        word(seq[9]);
        reset_n = 1'b1;
        checks++;
        if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 ||
            bus.err_count !== 16'd0 || bus.word_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid l=%0b p=%0b e=%0d w=%0d exp=all 0",
                     bus.locked, bus.err_pulse,
                     bus.err_count, bus.word_count);
        end
        // After reset the stale expected word must not linger.
        lock_up();
        checks++;
        if (bus.locked !== 1'b1 || bus.err_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_relock l=%0b e=%0d exp=1/0",
                     bus.locked, bus.err_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lock_from_reset();
        test_single_error();
        test_loss_of_lock();
        test_zero_handling();
        test_gaps();
        test_clear();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
